add_carry_seq: RTL and testbench
================================

Name: add_carry_seq

Overview:
- Parametrised successor to the two-lane fraction carry register in the online (MSD-first) multiplier datapath.
- Feeds carry-outs from LANES redundant-digit adder lanes back as carry-ins through a DELAY-stage line.
- Sequences one online operation of DIGITS digit steps: start/done handshake, digit index, last-digit flag.
- Selectable clear-or-hold behaviour when a digit step is stalled.

Parameters:
- LANES, 2, number of adder lanes.
- CW, 2, carry width per lane (bits).
- DIGITS, 32, digit steps per operation (>=2).
- DELAY, 1, carry pipeline stages per lane (>=1).
- MODE_HOLD, 0, 0 = clear carries on stall cycles; 1 = hold carries on stall cycles.

Ports:
- clk, input, 1, rising-edge clock.
- asyn_reset, input, 1, reset: synchronous, active-high.
- start, input, 1, pulse to begin an operation.
- add_enable, input, 1, digit-step strobe; 0 = stall.
- cout_frac, input, LANES*CW, lane carry-outs; lane i in bits [i*CW +: CW].
- cin_frac, output, LANES*CW, lane carry-ins taken from the last delay stage.
- digit_idx, output, CNT_W, current digit index, where CNT_W = clog2(DIGITS).
- busy, output, 1, high in RUN.
- last_digit, output, 1, combinational; high when RUN and digit_idx == DIGITS-1.
- done, output, 1, one-cycle pulse after the final step.

Behaviour:
- The clock is clk. Reset is asyn_reset, synchronous and active-high.
- Reset, sampled at a rising edge: state IDLE; all delay stages 0; digit_idx 0; busy, done and last_digit 0; cin_frac 0.
- Reset takes priority over every other input, including mid-operation. There is no done pulse after a reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - cin_frac = 0.
  - start=1 -> RUN next cycle, with digit_idx = 0 and all stages cleared.
  - add_enable is ignored.
- RUN:
  - busy = 1. A step is any cycle with add_enable = 1.
  - On a step: stage0 <= lane cout_frac; stage k <= stage k-1; digit_idx increments.
  - On a stall with MODE_HOLD=0: all stages <= 0 and digit_idx holds.
  - On a stall with MODE_HOLD=1: all stages and digit_idx hold.
  - A step with last_digit=1 -> DONE; all stages cleared; digit_idx returns to 0.
  - start is ignored while in RUN.
- DONE: lasts one cycle.
  - done = 1, busy = 0, cin_frac = 0.
  - start=1 in this cycle -> RUN directly (back-to-back operation, stages cleared). Otherwise -> IDLE.
- Latency:
  - A carry-out presented at step n appears on cin_frac for step n+DELAY.
  - The first DELAY steps of an operation see cin_frac = 0.
- Width rules:
  - Carries are passed bit-exact; no arithmetic is applied to them.
  - digit_idx never exceeds DIGITS-1 and never wraps within an operation.
- Lanes are independent and share the step, clear and hold controls.
- Simultaneous events: start together with add_enable in IDLE starts the operation only. That cycle is not counted as a step.

Decomposition:
- Package add_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing CNT_W from DIGITS;
  - the lane-slice helper constant for CW.
- Sub-module carry_delay_line: one lane, CW wide, DELAY stages.
  - Inputs: step, clear, din. Output: dout.
  - Instantiated LANES times by a generate loop.
- The top level holds the FSM, the counter and the MODE_HOLD select of clear versus hold.

Test Plan:
- Configuration for all scenarios: LANES=2, CW=2, DIGITS=4, DELAY=1.
- Steady run: start, then 4 consecutive steps with cout_frac = 4'b0110, 4'b1001, 4'b0011, 4'b1100.
  - cin_frac = 0, 0110, 1001, 0011 on steps 0-3.
  - last_digit high on step 3; done pulses the next cycle; IDLE after that.
- Stall with MODE_HOLD=0: after step 1 (cout_frac 4'b1001), hold add_enable low 2 cycles.
  - cin_frac = 0 during the stall; digit_idx stays at 2.
  - On the resumed step, cin_frac = 0 and digit_idx is still 2.
- Stall with MODE_HOLD=1: same stimulus.
  - cin_frac holds 4'b1001 through the stall and on the resumed step.
- DELAY=2 run: cout_frac = 4'b0101 on step 0.
  - The value appears on cin_frac at step 2.
  - cin_frac = 0 on steps 0-1.
- Back-to-back and reset:
  - start asserted in the DONE cycle -> busy the next cycle, digit_idx = 0, cin_frac = 0.
  - asyn_reset asserted at digit_idx = 2 -> next cycle all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/add_ctrl_pkg.sv
// Shared types and helpers for the online-multiplier carry sequencer.
package add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a digit index able to reach digits-1; never narrower than one bit.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int cw);
        return lane * cw;
    endfunction

endpackage

// File: rtl/carry_delay_line.sv
// One lane of carry feedback: a DELAY-deep shift line with step, clear and hold.
module carry_delay_line #(
    parameter int CW    = 2,
    parameter int DELAY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          clear,
    input  logic [CW-1:0] din,
    output logic [CW-1:0] dout
);

    logic [CW-1:0] stage_q [DELAY];
    logic [CW-1:0] stage_d [DELAY];

    // Clear wins over step; with neither asserted every stage holds.
    always_comb begin
        for (int k = 0; k < DELAY; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (clear) begin
            for (int k = 0; k < DELAY; k++) begin
                stage_d[k] = '0;
            end
        end else if (step) begin
            stage_d[0] = din;
            for (int k = 1; k < DELAY; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DELAY; k++) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign dout = stage_q[DELAY-1];

endmodule

// File: rtl/add_carry_seq.sv
// Carry feedback register for the online multiplier: LANES delay lines plus the
// IDLE/RUN/DONE sequencer that counts DIGITS digit steps per operation.
module add_carry_seq
    import add_ctrl_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int CW        = 2,
    parameter int DIGITS    = 32,
    parameter int DELAY     = 1,
    parameter bit MODE_HOLD = 1'b0,
    localparam int CNT_W    = cnt_width(DIGITS)
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                start,
    input  logic                add_enable,
    input  logic [LANES*CW-1:0] cout_frac,
    output logic [LANES*CW-1:0] cin_frac,
    output logic [CNT_W-1:0]    digit_idx,
    output logic                busy,
    output logic                last_digit,
    output logic                done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               in_run, is_last, step, clear;
    logic [LANES*CW-1:0] line_out;

    assign in_run  = (state_q == RUN);
    assign is_last = in_run && (idx_q == LAST_IDX);
    assign step    = in_run && add_enable;

    // Lines stay cleared outside RUN so every operation starts from zero carries.
    assign clear = !in_run || (step && is_last) || (in_run && !add_enable && !MODE_HOLD);

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (add_enable && is_last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (!in_run || (step && is_last)) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // A stalled step in clear mode has no meaningful carry, so it is masked at once.
    always_comb begin
        busy       = in_run;
        done       = (state_q == DONE);
        last_digit = is_last;
        digit_idx  = idx_q;
        cin_frac   = '0;
        if (in_run && (add_enable || MODE_HOLD)) begin
            cin_frac = line_out;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        carry_delay_line #(
            .CW    (CW),
            .DELAY (DELAY)
        ) u_line (
            .clk   (clk),
            .reset (asyn_reset),
            .step  (step),
            .clear (clear),
            .din   (cout_frac[lane_lsb(g, CW) +: CW]),
            .dout  (line_out[lane_lsb(g, CW) +: CW])
        );
    end

endmodule

// File: tb/tb_add_carry_seq.sv
// Scoreboard bench: three instances (clear/DELAY=1, hold/DELAY=1, clear/DELAY=2)
// share one directed stimulus stream with hand-computed per-instance expectations.
module tb_add_carry_seq;

    typedef struct packed {
        logic [3:0] cin;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       start;
    logic       add_enable;
    logic [3:0] cout_frac;

    logic [3:0] cin0, cin1, cin2;
    logic [1:0] idx0, idx1, idx2;
    logic       busy0, busy1, busy2;
    logic       last0, last1, last2;
    logic       done0, done1, done2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int  errors = 0;
    int  checks = 0;
    int  done_cnt [3] = '{0, 0, 0};
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    add_carry_seq #(.LANES(2), .CW(2), .DIGITS(4), .DELAY(1), .MODE_HOLD(1'b0)) dut0 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .add_enable(add_enable),
        .cout_frac(cout_frac), .cin_frac(cin0), .digit_idx(idx0), .busy(busy0),
        .last_digit(last0), .done(done0)
    );

    add_carry_seq #(.LANES(2), .CW(2), .DIGITS(4), .DELAY(1), .MODE_HOLD(1'b1)) dut1 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .add_enable(add_enable),
        .cout_frac(cout_frac), .cin_frac(cin1), .digit_idx(idx1), .busy(busy1),
        .last_digit(last1), .done(done1)
    );

    add_carry_seq #(.LANES(2), .CW(2), .DIGITS(4), .DELAY(2), .MODE_HOLD(1'b0)) dut2 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .add_enable(add_enable),
        .cout_frac(cout_frac), .cin_frac(cin2), .digit_idx(idx2), .busy(busy2),
        .last_digit(last2), .done(done2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic monitorOne(input int k, input logic b, input logic d,
                              input logic [3:0] c, input logic [1:0] i, input logic l);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (b === 1'b1) begin
            case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut%0d unexpected busy: got busy=1, expected busy=0 at %0t", k, $time);
            end else begin
                checkOutput($sformatf("dut%0d run {cin,idx,last}", k), {c, i, l}, e);
            end
        end else begin
            checkOutput($sformatf("dut%0d idle {cin,idx,last}", k), {c, i, l}, 7'd0);
        end
        if (d === 1'b1) done_cnt[k]++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            monitorOne(0, busy0, done0, cin0, idx0, last0);
            monitorOne(1, busy1, done1, cin1, idx1, last1);
            monitorOne(2, busy2, done2, cin2, idx2, last2);
        end
    end

    task automatic applyStimulus(input logic s, input logic en, input logic [3:0] co,
                                 input bit run, input logic [3:0] e0, input logic [3:0] e1,
                                 input logic [3:0] e2, input logic [1:0] idx, input logic last);
        start      = s;
        add_enable = en;
        cout_frac  = co;
        if (run) begin
            q0.push_back('{cin: e0, idx: idx, last: last});
            q1.push_back('{cin: e1, idx: idx, last: last});
            q2.push_back('{cin: e2, idx: idx, last: last});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string name, input logic exp_done, input logic exp_busy);
        checkOutput({name, " done0"}, done0, exp_done);
        checkOutput({name, " done1"}, done1, exp_done);
        checkOutput({name, " done2"}, done2, exp_done);
        checkOutput({name, " busy0"}, busy0, exp_busy);
        checkOutput({name, " busy1"}, busy1, exp_busy);
        checkOutput({name, " busy2"}, busy2, exp_busy);
    endtask

    initial begin
        asyn_reset = 1'b1;
        start      = 1'b0;
        add_enable = 1'b0;
        cout_frac  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        mon_en     = 1'b1;
        checkFlags("reset", 1'b0, 1'b0);

        // Steady run; start with add_enable in IDLE must not count as a step.
        applyStimulus(1, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h6, 1, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h9, 1, 4'h6, 4'h6, 4'h0, 2'd1, 0);
        applyStimulus(0, 1, 4'h3, 1, 4'h9, 4'h9, 4'h6, 2'd2, 0);
        applyStimulus(0, 1, 4'hC, 1, 4'h3, 4'h3, 4'h9, 2'd3, 1);
        checkFlags("steady done cycle", 1'b1, 1'b0);
        applyStimulus(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        checkFlags("steady after done", 1'b0, 1'b0);
        applyStimulus(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);

        // Two-cycle stall after step 1: clear mode drops carries, hold mode keeps them.
        applyStimulus(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h6, 1, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h9, 1, 4'h6, 4'h6, 4'h0, 2'd1, 0);
        applyStimulus(0, 0, 4'hF, 1, 4'h0, 4'h9, 4'h0, 2'd2, 0);
        applyStimulus(0, 0, 4'hF, 1, 4'h0, 4'h9, 4'h0, 2'd2, 0);
        applyStimulus(0, 1, 4'h3, 1, 4'h0, 4'h9, 4'h0, 2'd2, 0);
        applyStimulus(0, 1, 4'hC, 1, 4'h3, 4'h3, 4'h0, 2'd3, 1);
        checkFlags("stall done cycle", 1'b1, 1'b0);

        // Back-to-back: start in the DONE cycle, then reset mid-operation at idx 2.
        applyStimulus(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        checkFlags("back-to-back", 1'b0, 1'b1);
        applyStimulus(0, 0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h6, 1, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        applyStimulus(0, 1, 4'h9, 1, 4'h6, 4'h6, 4'h0, 2'd1, 0);
        asyn_reset = 1'b1;
        applyStimulus(0, 1, 4'h3, 1, 4'h9, 4'h9, 4'h6, 2'd2, 0);
        asyn_reset = 1'b0;
        checkFlags("after reset", 1'b0, 1'b0);
        applyStimulus(0, 1, 4'h5, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        checkFlags("idle after reset", 1'b0, 1'b0);
        applyStimulus(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        @(negedge clk);
        mon_en = 1'b0;

        checkOutput("dut0 pending expectations", q0.size(), 0);
        checkOutput("dut1 pending expectations", q1.size(), 0);
        checkOutput("dut2 pending expectations", q2.size(), 0);
        checkOutput("dut0 done pulses", done_cnt[0], 2);
        checkOutput("dut1 done pulses", done_cnt[1], 2);
        checkOutput("dut2 done pulses", done_cnt[2], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
